// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_pkg
//  Description : Shared types and constants for the QPSK transmitter. It holds
//                the FSM state enum, the sync byte, the default amplitude, the
//                dibit width and two small helpers that split a byte into its
//                first dibit and its remaining dibits.
//                The SYNC state only exists when QPSK_TX_SYNC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package qpsk_pkg;

`ifdef QPSK_TX_SYNC_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_SYNC  = 2'd3
    } qpsk_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } qpsk_state_e;
`endif

    localparam logic [7:0] SYNC_BYTE   = 8'hE4;
    localparam int         DEFAULT_AMP = 64;
    localparam int         DIBIT_W     = 2;

    // Dibit [7:6] is always transmitted first.
    function automatic logic [DIBIT_W-1:0] first_dibit(input logic [7:0] b);
        return b[7:6];
    endfunction

    // Dibits still to be sent after the first one, MSB-aligned.
    function automatic logic [5:0] rest_dibits(input logic [7:0] b);
        return b[5:0];
    endfunction

endpackage : qpsk_pkg
`default_nettype wire

// File: rtl/qpsk_sym_map.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_sym_map
//  Description : Combinational Gray mapper, one dibit to one (I,Q) point.
//                00 -> (+A,+A), 01 -> (-A,+A), 11 -> (-A,-A), 10 -> (+A,-A)
//                Bit 0 of the dibit selects the I sign, bit 1 the Q sign.
//  Ports       : dibit_i  - dibit to map
//                i_val_o  - signed 8-bit I value
//                q_val_o  - signed 8-bit Q value
//  Revision    : 1.0 - initial release
// ============================================================================
module qpsk_sym_map
    import qpsk_pkg::*;
#(
    parameter int AMP = DEFAULT_AMP
)(
    input  logic [DIBIT_W-1:0] dibit_i,
    output logic signed [7:0]  i_val_o,
    output logic signed [7:0]  q_val_o
);

    localparam logic signed [7:0] c_amp_pos = 8'(AMP);
    localparam logic signed [7:0] c_amp_neg = 8'(-AMP);

    assign i_val_o = dibit_i[0] ? c_amp_neg : c_amp_pos;
    assign q_val_o = dibit_i[1] ? c_amp_neg : c_amp_pos;

endmodule : qpsk_sym_map
`default_nettype wire

// File: rtl/qpsk_tx.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_tx
//  Description : Byte-stream QPSK symbol generator. It pulls bytes from an
//                upstream FIFO and emits 4 Gray-mapped symbols per byte, MSB
//                dibit first, one symbol every SYM_DIV clocks. It prefetches
//                the next byte during symbol 2, so back-to-back bytes stream
//                with no gap.
//                Optional: QPSK_TX_SYNC_EN inserts 4 symbols of SYNC_BYTE
//                before every byte that starts from IDLE.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-high reset
//                fifo_empty - upstream FIFO has no data
//                fifo_data  - FIFO byte, valid the cycle after rd_en
//                rd_en      - one-cycle FIFO read request
//                sym_i      - signed I of the current symbol (0 in IDLE)
//                sym_q      - signed Q of the current symbol (0 in IDLE)
//                iq_valid   - one-cycle pulse at the start of each symbol
//                busy       - state is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module qpsk_tx
    import qpsk_pkg::*;
#(
    parameter int AMP     = DEFAULT_AMP,
    parameter int SYM_DIV = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [7:0]        fifo_data,
    output logic              rd_en,
    output logic signed [7:0] sym_i,
    output logic signed [7:0] sym_q,
    output logic              iq_valid,
    output logic              busy
);

    localparam int                 c_div_w    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SYM_DIV - 1);

    qpsk_state_e        state_q, state_d;
    logic [5:0]         rem_q, rem_d;        // dibits not yet issued, MSB first
    logic [1:0]         sym_idx_q, sym_idx_d;
    logic [c_div_w-1:0] div_q, div_d;
    logic [7:0]         nb_q, nb_d;          // next-byte buffer
    logic               nb_full_q, nb_full_d;
    logic               nb_pend_q, nb_pend_d; // prefetch read in flight
    logic               iq_valid_q, iq_valid_d;
    logic signed [7:0]  out_i_q, out_i_d;
    logic signed [7:0]  out_q_q, out_q_d;

    logic               w_rd_req;
    logic               w_active;
    logic               w_period_end;
    logic               w_last_sym;
    logic [7:0]         w_nb_src;
    logic [DIBIT_W-1:0] w_map_dibit;
    logic signed [7:0]  w_map_i;
    logic signed [7:0]  w_map_q;

    // The outputs are registered, so the mapper always works on the dibit
    // that becomes visible on the next clock.
    always_comb begin
        w_active = (state_q == ST_SEND);
`ifdef QPSK_TX_SYNC_EN
        if (state_q == ST_SYNC) begin
            w_active = 1'b1;
        end
`endif
        w_period_end = (div_q == c_div_last);
        w_last_sym   = (sym_idx_q == 2'd3);
        // With SYM_DIV=1 the prefetched byte is still on fifo_data when
        // symbol 3 ends, so take it straight from the bus in that case.
        w_nb_src     = nb_pend_q ? fifo_data : nb_q;
        if (state_q == ST_FETCH) begin
`ifdef QPSK_TX_SYNC_EN
            w_map_dibit = first_dibit(SYNC_BYTE);
`else
            w_map_dibit = first_dibit(fifo_data);
`endif
        end else if (w_last_sym) begin
            w_map_dibit = first_dibit(w_nb_src);
        end else begin
            w_map_dibit = rem_q[5:4];
        end
    end

    qpsk_sym_map #(
        .AMP (AMP)
    ) u_map (
        .dibit_i (w_map_dibit),
        .i_val_o (w_map_i),
        .q_val_o (w_map_q)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        sym_idx_d  = sym_idx_q;
        div_d      = div_q;
        nb_d       = nb_q;
        nb_full_d  = nb_full_q;
        nb_pend_d  = nb_pend_q;
        iq_valid_d = 1'b0;
        out_i_d    = out_i_q;
        out_q_d    = out_q_q;
        w_rd_req   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    w_rd_req = 1'b1;
                    state_d  = ST_FETCH;
                end
            end

            ST_FETCH: begin
                sym_idx_d  = 2'd0;
                div_d      = '0;
                iq_valid_d = 1'b1;
                out_i_d    = w_map_i;
                out_q_d    = w_map_q;
`ifdef QPSK_TX_SYNC_EN
                // Park the data byte in the next-byte buffer while the
                // sync byte goes out; it is reloaded like a prefetched byte.
                rem_d     = rest_dibits(SYNC_BYTE);
                nb_d      = fifo_data;
                nb_full_d = 1'b1;
                state_d   = ST_SYNC;
`else
                rem_d     = rest_dibits(fifo_data);
                state_d   = ST_SEND;
`endif
            end

            default: begin
                if (w_active) begin
                    if ((state_q == ST_SEND) && (sym_idx_q == 2'd2) && (div_q == '0) &&
                        !fifo_empty && !nb_full_q && !nb_pend_q) begin
                        w_rd_req  = 1'b1;
                        nb_pend_d = 1'b1;
                    end
                    if (nb_pend_q) begin
                        nb_d      = fifo_data;
                        nb_full_d = 1'b1;
                        nb_pend_d = 1'b0;
                    end
                    if (w_period_end) begin
                        div_d = '0;
                        if (!w_last_sym) begin
                            sym_idx_d  = sym_idx_q + 2'd1;
                            rem_d      = {rem_q[3:0], 2'b00};
                            iq_valid_d = 1'b1;
                            out_i_d    = w_map_i;
                            out_q_d    = w_map_q;
                        end else if (nb_full_q || nb_pend_q) begin
                            sym_idx_d  = 2'd0;
                            rem_d      = rest_dibits(w_nb_src);
                            nb_full_d  = 1'b0;
                            nb_pend_d  = 1'b0;
                            iq_valid_d = 1'b1;
                            out_i_d    = w_map_i;
                            out_q_d    = w_map_q;
                            state_d    = ST_SEND;
                        end else begin
                            sym_idx_d = 2'd0;
                            out_i_d   = '0;
                            out_q_d   = '0;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        div_d = div_q + c_div_w'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            sym_idx_q  <= '0;
            div_q      <= '0;
            nb_q       <= '0;
            nb_full_q  <= 1'b0;
            nb_pend_q  <= 1'b0;
            iq_valid_q <= 1'b0;
            out_i_q    <= '0;
            out_q_q    <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            sym_idx_q  <= sym_idx_d;
            div_q      <= div_d;
            nb_q       <= nb_d;
            nb_full_q  <= nb_full_d;
            nb_pend_q  <= nb_pend_d;
            iq_valid_q <= iq_valid_d;
            out_i_q    <= out_i_d;
            out_q_q    <= out_q_d;
        end
    end

    // The read request is combinational from IDLE; gate it so that it drops
    // the moment reset is applied rather than at the next edge.
    assign rd_en    = w_rd_req & ~reset;
    assign sym_i    = out_i_q;
    assign sym_q    = out_q_q;
    assign iq_valid = iq_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule : qpsk_tx
`default_nettype wire

// File: doc/qpsk_tx.md
QPSK_TX -- requirements
Module: qpsk_tx

Interface
REQ-001 Parameter AMP, default 64, signed 8-bit symbol amplitude magnitude (1..127).
REQ-002 Parameter SYM_DIV, default 1, clocks per symbol period (>=1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream byte FIFO has no data.
REQ-006 fifo_data  input  8  byte from FIFO, valid the cycle after rd_en.
REQ-007 rd_en  output  1  one-cycle read request to upstream FIFO.
REQ-008 sym_i  output  8  signed I value of current symbol.
REQ-009 sym_q  output  8  signed Q value of current symbol.
REQ-010 iq_valid  output  1  one-cycle pulse, sym_i/sym_q valid.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Each byte SHALL produce exactly 4 symbols, dibit order [7:6],[5:4],[3:2],[1:0].
REQ-013 Gray map SHALL be 00->(+AMP,+AMP), 01->(-AMP,+AMP), 11->(-AMP,-AMP), 10->(+AMP,-AMP).
REQ-014 States SHALL be IDLE, FETCH, SEND (plus SYNC when REQ-024 enabled).
REQ-015 IDLE: if !fifo_empty, assert rd_en for one cycle and go to FETCH; else stay.
REQ-016 FETCH: capture fifo_data into shift register, clear sym_idx and divider, go to SEND (or SYNC).
REQ-017 SEND: iq_valid pulses on the first cycle of each SYM_DIV-cycle period; sym_i/sym_q registered, held until next symbol.
REQ-018 Prefetch: in the cycle the symbol with sym_idx==2 is issued, if !fifo_empty and next-byte buffer empty, assert rd_en; capture fifo_data into next-byte buffer next cycle.
REQ-019 At end of symbol 3 period: if next-byte buffer full, load it, clear it, continue SEND with no idle period (gapless stream for all SYM_DIV); else go to IDLE.
REQ-020 rd_en SHALL never assert when fifo_empty is high; at most one outstanding read.
REQ-021 Symbol rate: with SYM_DIV=1 and FIFO never empty, iq_valid high every cycle after first symbol.
REQ-022 Latency: first iq_valid exactly 2 cycles after the rd_en from IDLE (sync disabled).
REQ-023 Outside iq_valid pulses sym_i/sym_q SHALL hold last value; in IDLE they SHALL be 0.

Configuration
REQ-024 Macro QPSK_TX_SYNC_EN defined: on entry from IDLE (not on gapless continuation), emit 4 symbols of SYNC_BYTE 8'hE4 in SYNC state before the data byte; undefined: SYNC state absent, FETCH goes directly to SEND.

Reset
REQ-025 On reset assertion, immediately: state IDLE, rd_en 0, iq_valid 0, sym_i 0, sym_q 0, busy 0, sym_idx 0, divider 0, next-byte buffer empty.
REQ-026 Reset mid-byte SHALL discard in-flight and prefetched bytes; no further symbols emitted for them.

Structure
REQ-027 Package qpsk_pkg SHALL hold state enum, SYNC_BYTE, default AMP, and dibit width constant.
REQ-028 Sub-module qpsk_sym_map SHALL implement combinational dibit->(I,Q) mapping of REQ-013.

Verification
REQ-029 FIFO holds 8'h1B, SYM_DIV=1, AMP=64 -> symbols (64,64),(-64,64),(64,-64),(-64,-64), then IDLE, busy 0.
REQ-030 FIFO holds 8'h00,8'hFF, SYM_DIV=1 -> 8 consecutive iq_valid cycles, no gap, 4x(64,64) then 4x(-64,-64).
REQ-031 SYM_DIV=3, byte 8'hE4 -> iq_valid every 3rd cycle, values held between pulses, exactly 4 pulses.
REQ-032 FIFO empties after first byte -> no rd_en while fifo_empty high; return to IDLE after symbol 3.
REQ-033 Reset asserted during symbol 1 of a byte with prefetched byte pending -> all outputs 0 at once, no symbols after release until FIFO non-empty.
REQ-034 QPSK_TX_SYNC_EN defined, byte 8'h00 -> sync symbols (-64,-64),(64,-64),(-64,64),(64,64) then 4x(64,64).
